// File: rtl/mult_unit.sv
// mult_unit: sequential radix-2 shift-add multiplier for the mult/multu
// instructions. An operation takes WIDTH+1 clock edges from start to a
// done pulse. The hi/lo result registers hold their value between
// operations, so mfhi/mflo can read them.
module mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_signed;
    logic               r_sign;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_count;

    logic [WIDTH-1:0]   w_magA;
    logic [WIDTH-1:0]   w_magB;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_accNext;
    logic [2*WIDTH-1:0] w_accNeg;

    // Operand magnitudes; the most negative value negates to itself, which
    // read as unsigned is exactly 2^(WIDTH-1), so no extra bit is needed.
    always_comb begin
        w_magA = a;
        w_magB = b;
        if (is_signed && a[WIDTH-1]) w_magA = ~a + 1'b1;
        if (is_signed && b[WIDTH-1]) w_magB = ~b + 1'b1;
    end

    // One shift-add step: conditionally add the multiplicand into the upper
    // half (keeping the carry) and shift the whole accumulator right by one.
    always_comb begin
        w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]};
        if (r_mplier[0]) w_sum = w_sum + {1'b0, r_mcand};
        w_accNext = {w_sum, r_acc[WIDTH-1:1]};
        w_accNeg  = ~r_acc + 1'b1;
    end

    // Control FSM plus datapath registers; busy and done are registered
    // alongside the state so they change only on edges (or reset).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_signed <= 1'b0;
            r_sign   <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_signed <= is_signed;
                        r_sign   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_mcand  <= w_magA;
                        r_mplier <= w_magB;
                        r_acc    <= '0;
                        r_count  <= '0;
                        busy     <= 1'b1;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_acc    <= w_accNext;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + 1'b1;
                    if (r_count == CW'(WIDTH - 1)) r_state <= FINISH;
                end
                FINISH: begin
                    if (r_signed && r_sign) {hi, lo} <= w_accNeg;
                    else                    {hi, lo} <= r_acc;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_unit.sv
// tb_mult_unit: directed and random multiplies for mult_unit (WIDTH=32).
// Expected products come from plain 64-bit arithmetic.
module tb_mult_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int assertCount;
    int failCount;
    logic [31:0] modelHi;
    logic [31:0] modelLo;

    mult_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done)
    );

    // Free-running clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference product from ordinary integer multiplication.
    function automatic logic [63:0] refProduct(input logic [31:0] x, input logic [31:0] y,
                                               input logic s);
        longint sx;
        longint sy;
        logic [63:0] ux;
        logic [63:0] uy;
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        ux = {32'b0, x};
        uy = {32'b0, y};
        return ux * uy;
    endfunction

    // One comparison: counted, and reported on mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one complete operation. Called at posedge+1 with the DUT idle.
    // glitchEdge (1..32) re-pulses start with 7*9 mid-operation; 0 = none.
    // Returns at posedge+1 after E33, i.e. in the cycle where done is high.
    task automatic applyStimulus(input logic [31:0] opA, input logic [31:0] opB,
                                 input logic sgn, input int glitchEdge);
        logic [63:0] expP;
        expP = refProduct(opA, opB, sgn);
        a = opA;
        b = opB;
        is_signed = sgn;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        is_signed = 1'($urandom);
        checkOutput("e0_busy", 64'(busy), 64'd1);
        checkOutput("e0_done", 64'(done), 64'd0);
        for (int e = 1; e <= 32; e++) begin
            if (e == glitchEdge) begin
                start = 1'b1;
                a = 32'd7;
                b = 32'd9;
                is_signed = 1'b0;
            end
            @(posedge clk); #1;
            start = 1'b0;
            checkOutput("run_busy", 64'(busy), 64'd1);
            checkOutput("run_done", 64'(done), 64'd0);
            if (e == 1 || e == 16 || e == 32)
                checkOutput("run_hold", {hi, lo}, {modelHi, modelLo});
        end
        @(posedge clk); #1;
        modelHi = expP[63:32];
        modelLo = expP[31:0];
        checkOutput("fin_done", 64'(done), 64'd1);
        checkOutput("fin_busy", 64'(busy), 64'd0);
        checkOutput("fin_hi", 64'(hi), 64'(modelHi));
        checkOutput("fin_lo", 64'(lo), 64'(modelLo));
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        modelHi     = '0;
        modelLo     = '0;
        reset       = 1'b1;
        start       = 1'b0;
        is_signed   = 1'b0;
        a           = '0;
        b           = '0;
        #1;
        checkOutput("rst_hi", 64'(hi), 64'd0);
        checkOutput("rst_lo", 64'(lo), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Unsigned all-ones squared, then signed corner cases.
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0);
        checkOutput("uu_hi", 64'(hi), 64'hFFFFFFFE);
        checkOutput("uu_lo", 64'(lo), 64'h00000001);
        applyStimulus(32'hFFFFFFFD, 32'd5, 1'b1, 0);
        checkOutput("m3x5_hi", 64'(hi), 64'hFFFFFFFF);
        checkOutput("m3x5_lo", 64'(lo), 64'hFFFFFFF1);
        applyStimulus(32'h80000000, 32'h80000000, 1'b1, 0);
        checkOutput("minmin_hi", 64'(hi), 64'h40000000);
        checkOutput("minmin_lo", 64'(lo), 64'h0);

        // -1 * -1 signed, then same operands unsigned back-to-back.
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0);
        checkOutput("m1m1_hi", 64'(hi), 64'h0);
        checkOutput("m1m1_lo", 64'(lo), 64'h1);
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0);
        checkOutput("b2b_hi", 64'(hi), 64'hFFFFFFFE);
        checkOutput("b2b_lo", 64'(lo), 64'h00000001);

        // Start re-pulsed mid-operation must be ignored, with no second done.
        applyStimulus(32'd6, 32'd7, 1'b0, 10);
        checkOutput("ign_lo", 64'(lo), 64'd42);
        @(posedge clk); #1;
        checkOutput("ign_done_clr", 64'(done), 64'd0);
        checkOutput("ign_idle", 64'(busy), 64'd0);
        repeat (40) begin
            @(posedge clk); #1;
            if (done) break;
        end
        checkOutput("ign_no_2nd_done", 64'(done), 64'd0);
        checkOutput("ign_hold_lo", 64'(lo), 64'd42);

        // Zero operands keep the full latency.
        applyStimulus(32'd0, 32'h12345678, 1'b1, 0);
        applyStimulus(32'hDEADBEEF, 32'd0, 1'b0, 0);

        // Random operands, back-to-back.
        for (int i = 0; i < 8; i++)
            applyStimulus($urandom, $urandom, 1'($urandom), 0);

        // Reset during RUN: hi=0x12345678 beforehand, cleared asynchronously.
        applyStimulus(32'h2468ACF0, 32'h80000000, 1'b0, 0);
        checkOutput("pre_rst_hi", 64'(hi), 64'h12345678);
        @(posedge clk); #1;
        a = 32'd11;
        b = 32'd13;
        is_signed = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        checkOutput("mid_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        checkOutput("arst_hi", 64'(hi), 64'd0);
        checkOutput("arst_lo", 64'(lo), 64'd0);
        checkOutput("arst_busy", 64'(busy), 64'd0);
        checkOutput("arst_done", 64'(done), 64'd0);
        modelHi = '0;
        modelLo = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        applyStimulus(32'd2, 32'd3, 1'b0, 0);
        checkOutput("post_rst_hi", 64'(hi), 64'd0);
        checkOutput("post_rst_lo", 64'(lo), 64'd6);
        @(posedge clk); #1;
        checkOutput("final_done_clr", 64'(done), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/mult_unit.md
MULT_UNIT -- requirements
Module: mult_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits; the product is 2*WIDTH bits.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit, a multiply request, driven by the controller's startMult.
REQ-005 The block SHALL have port is_signed, input, 1 bit: 1 = mult (two's complement), 0 = multu; driven by signedMult.
REQ-006 The block SHALL have port a, input, WIDTH bits, multiplicand (rs value).
REQ-007 The block SHALL have port b, input, WIDTH bits, multiplier (rt value).
REQ-008 The block SHALL have port hi, output, WIDTH bits, upper half of the last completed product (mfhi source).
REQ-009 The block SHALL have port lo, output, WIDTH bits, lower half of the last completed product (mflo source).
REQ-010 The block SHALL have port busy, output, 1 bit, high while an operation is in progress (pipeline stall request for mfhi/mflo).
REQ-011 The block SHALL have port done, output, 1 bit, a registered one-cycle pulse marking hi/lo update.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and FINISH; busy SHALL be 1 in RUN and FINISH and 0 in IDLE.
REQ-013 In IDLE with start=1 at edge E0, the block SHALL latch is_signed, latch |a| and |b| (magnitudes when signed, raw values when unsigned), record sign = a[MSB]^b[MSB] (signed only, else 0), clear the accumulator and counter, and enter RUN.
REQ-014 Magnitudes SHALL be WIDTH-bit unsigned; the most negative operand (e.g. 0x80000000) SHALL map to magnitude 2^(WIDTH-1) without overflow.
REQ-015 In RUN, each edge SHALL perform one radix-2 shift-add step (add the multiplicand when the current multiplier LSB is 1, shift the 2*WIDTH accumulator right by one) and increment the counter.
REQ-016 RUN SHALL last exactly WIDTH edges (E1..E_WIDTH), after which the FSM SHALL enter FINISH.
REQ-017 At edge E_WIDTH+1 (FINISH), the block SHALL write {hi,lo} = the accumulator, two's-complement negated over 2*WIDTH bits if sign=1; it SHALL then enter IDLE and set done=1.
REQ-018 done SHALL clear on the next edge (E_WIDTH+2), unless cleared earlier by reset; total latency from start edge to hi/lo valid is WIDTH+1 edges (33 for WIDTH=32).
REQ-019 The start input SHALL be ignored while busy=1; no queuing, and operands latched at E0 SHALL be unaffected.
REQ-020 The block SHALL accept start in the IDLE cycle during which done=1 (back-to-back operation).
REQ-021 hi and lo SHALL hold their last value at all times except at the FINISH edge; a, b and is_signed changes after E0 SHALL have no effect.
REQ-022 Multiply-by-zero SHALL NOT shorten latency; every operation SHALL take WIDTH+1 edges.
REQ-023 The block SHALL NOT detect or report overflow; the full 2*WIDTH product always fits.

Reset
REQ-024 Assertion of reset SHALL immediately, without waiting for clk, force state=IDLE, hi=0, lo=0, busy=0, done=0, and clear the counter, accumulator and latched sign.
REQ-025 Reset asserted during RUN or FINISH SHALL abort the operation with no hi/lo update; after release, the block SHALL accept start on the first edge.

Verification
REQ-026 Unsigned: is_signed=0, a=0xFFFFFFFF, b=0xFFFFFFFF, start pulse -> busy high for 33 cycles; hi=0xFFFFFFFE, lo=0x00000001 with done pulse at E33.
REQ-027 Signed: a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; signed a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-028 Signed -1*-1 (a=b=0xFFFFFFFF, is_signed=1) -> hi=0, lo=1; same operands unsigned immediately after (start during done) -> REQ-026 result.
REQ-029 start re-pulsed with a=7, b=9 at E10 of an active 6*7 operation -> ignored; result hi=0, lo=42 at E33; no second done pulse.
REQ-030 reset asserted at E15 of an operation (hi previously 0x12345678) -> hi=lo=0, busy=0 asynchronously; a new 2*3 started after release -> lo=6 after 33 edges.
